// File: rtl/illusion_pkg.sv
// Shared types and defaults for the frame sequencing path between rasterizer and framebuffer.
package illusion_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRender,
        StWaitFlip
    } state_e;

    localparam int unsigned RenderingWidth  = 320;
    localparam int unsigned RenderingHeight = 240;
    localparam int unsigned PixelWidth      = 3;

endpackage

// File: rtl/framebuffer_clearer.sv
// Clear-address generator: one address per cycle while start_i is held, wrapping after size_i.
module framebuffer_clearer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_i,
    input  logic [31:0] size_i,
    output logic [31:0] addr_o,
    output logic        enable_o,
    output logic        last_o
);

    logic [31:0] cnt_q, cnt_d;

    assign enable_o = start_i;
    assign addr_o   = base_i + cnt_q;
    assign last_o   = start_i && (cnt_q == size_i - 32'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = last_o ? 32'd0 : cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Frame sequencer: clears the back buffer, runs the rasterizer into it, flips on vertical blank.
module frame_scheduler
    import illusion_pkg::*;
#(
    parameter int unsigned           RENDERING_WIDTH  = RenderingWidth,
    parameter int unsigned           RENDERING_HEIGHT = RenderingHeight,
    parameter logic [PixelWidth-1:0] CLEAR_COLOR      = '0
) (
    input  logic                  aClock,
    input  logic                  aReset,
    input  logic                  aVSync,
    input  logic                  aRenderDone,
    input  logic [31:0]           aRenderPixelAddr,
    input  logic [PixelWidth-1:0] aRenderPixelData,
    input  logic                  aRenderPixelValid,
    output logic                  anOutRenderStart,
    output logic                  anOutWriteEnable,
    output logic [31:0]           anOutWriteAddr,
    output logic [PixelWidth-1:0] anOutWriteData,
    output logic                  anOutFrontBuffer,
    output logic [15:0]           anOutFrameCount,
    output logic                  anOutMissedVSync
);

    localparam logic [63:0] FbSizeWide = 64'(RENDERING_WIDTH) * 64'(RENDERING_HEIGHT);
    localparam logic [31:0] FbSize     = FbSizeWide[31:0];

    // Both buffers must be addressable with 32-bit arithmetic.
    if (FbSizeWide * 64'd2 >= 64'h1_0000_0000) begin : g_size_check
        $error("frame_scheduler: two framebuffers exceed the 32-bit address space");
    end

    state_e                state_q, state_d;
    logic                  front_q, front_d;
    logic [15:0]           count_q, count_d;
    logic [1:0]            guard_q, guard_d;
    logic                  start_q, start_d;
    logic                  we_q, we_d;
    logic [31:0]           waddr_q, waddr_d;
    logic [PixelWidth-1:0] wdata_q, wdata_d;
    logic                  missed_q, missed_d;
    logic                  clear_done_q, clear_done_d;

    logic        clr_run, clr_en, clr_last;
    logic [31:0] clr_addr, back_base;

    assign back_base = front_q ? 32'd0 : FbSize;
    // The clearer runs one cycle ahead of its registered write, so IDLE issues the first address.
    assign clr_run = (state_q == StIdle) || ((state_q == StClear) && !clear_done_q);

    framebuffer_clearer u_clearer (
        .clk_i    (aClock),
        .rst_i    (aReset),
        .start_i  (clr_run),
        .base_i   (back_base),
        .size_i   (FbSize),
        .addr_o   (clr_addr),
        .enable_o (clr_en),
        .last_o   (clr_last)
    );

    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        count_d      = count_q;
        guard_d      = guard_q;
        start_d      = 1'b0;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        missed_d     = 1'b0;
        clear_done_d = clr_last;

        unique case (state_q)
            StIdle: begin
                missed_d = aVSync;
                state_d  = StClear;
            end
            StClear: begin
                missed_d = aVSync;
                if (clear_done_q) begin
                    state_d = StRender;
                    start_d = 1'b1;
                    guard_d = 2'd0;
                end
            end
            StRender: begin
                missed_d = aVSync;
                // Done is still high from the previous frame until the rasterizer sees the start.
                if (guard_q != 2'd2) begin
                    guard_d = guard_q + 2'd1;
                end else if (aRenderDone) begin
                    state_d = StWaitFlip;
                end
            end
            StWaitFlip: begin
                if (aVSync) begin
                    front_d = ~front_q;
                    count_d = count_q + 16'd1;
                    state_d = StClear;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clr_en) begin
            we_d    = 1'b1;
            waddr_d = clr_addr;
            wdata_d = CLEAR_COLOR;
        end else if ((state_q == StRender) && aRenderPixelValid && (aRenderPixelAddr < FbSize)) begin
            we_d    = 1'b1;
            waddr_d = back_base + aRenderPixelAddr;
            wdata_d = aRenderPixelData;
        end
    end

    always_ff @(posedge aClock) begin
        if (aReset) begin
            state_q      <= StIdle;
            front_q      <= 1'b0;
            count_q      <= 16'd0;
            guard_q      <= 2'd0;
            start_q      <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= 32'd0;
            wdata_q      <= '0;
            missed_q     <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            count_q      <= count_d;
            guard_q      <= guard_d;
            start_q      <= start_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            missed_q     <= missed_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign anOutRenderStart = start_q;
    assign anOutWriteEnable = we_q;
    assign anOutWriteAddr   = waddr_q;
    assign anOutWriteData   = wdata_q;
    assign anOutFrontBuffer = front_q;
    assign anOutFrameCount  = count_q;
    assign anOutMissedVSync = missed_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler on a 4x2 framebuffer (FB_SIZE = 8).
module tb_frame_scheduler;

    logic        aClock = 1'b0;
    logic        aReset;
    logic        aVSync;
    logic        aRenderDone;
    logic [31:0] aRenderPixelAddr;
    logic [2:0]  aRenderPixelData;
    logic        aRenderPixelValid;
    logic        anOutRenderStart;
    logic        anOutWriteEnable;
    logic [31:0] anOutWriteAddr;
    logic [2:0]  anOutWriteData;
    logic        anOutFrontBuffer;
    logic [15:0] anOutFrameCount;
    logic        anOutMissedVSync;

    int checks = 0;
    int passed = 0;

    frame_scheduler #(
        .RENDERING_WIDTH  (4),
        .RENDERING_HEIGHT (2),
        .CLEAR_COLOR      (3'b000)
    ) dut (
        .aClock            (aClock),
        .aReset            (aReset),
        .aVSync            (aVSync),
        .aRenderDone       (aRenderDone),
        .aRenderPixelAddr  (aRenderPixelAddr),
        .aRenderPixelData  (aRenderPixelData),
        .aRenderPixelValid (aRenderPixelValid),
        .anOutRenderStart  (anOutRenderStart),
        .anOutWriteEnable  (anOutWriteEnable),
        .anOutWriteAddr    (anOutWriteAddr),
        .anOutWriteData    (anOutWriteData),
        .anOutFrontBuffer  (anOutFrontBuffer),
        .anOutFrameCount   (anOutFrameCount),
        .anOutMissedVSync  (anOutMissedVSync)
    );

    always #5 aClock = ~aClock;

    task automatic step();
        @(negedge aClock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expects the first clear write to be visible now; leaves the bench at the start-pulse cycle.
    task automatic check_clear(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            check("clear_we", 32'(anOutWriteEnable), 32'd1);
            check("clear_addr", anOutWriteAddr, base + 32'(i));
            check("clear_data", 32'(anOutWriteData), 32'd0);
            check("clear_no_start", 32'(anOutRenderStart), 32'd0);
            step();
        end
        check("start_pulse", 32'(anOutRenderStart), 32'd1);
        check("start_no_we", 32'(anOutWriteEnable), 32'd0);
    endtask

    initial begin
        aReset = 1'b1;
        aVSync = 1'b0;
        aRenderDone = 1'b1;
        aRenderPixelAddr = 32'd0;
        aRenderPixelData = 3'd0;
        aRenderPixelValid = 1'b0;
        step();
        step();
        check("rst_we", 32'(anOutWriteEnable), 32'd0);
        check("rst_addr", anOutWriteAddr, 32'd0);
        check("rst_data", 32'(anOutWriteData), 32'd0);
        check("rst_front", 32'(anOutFrontBuffer), 32'd0);
        check("rst_count", 32'(anOutFrameCount), 32'd0);
        check("rst_start", 32'(anOutRenderStart), 32'd0);
        check("rst_missed", 32'(anOutMissedVSync), 32'd0);

        // Frame 1: back buffer 1 at base 8.
        aReset = 1'b0;
        step();
        check_clear(32'd8);
        step();
        check("start_one_cycle", 32'(anOutRenderStart), 32'd0);
        step();
        aRenderDone = 1'b0;
        aRenderPixelValid = 1'b1;
        aRenderPixelAddr = 32'd3;
        aRenderPixelData = 3'd5;
        step();
        check("pix_we", 32'(anOutWriteEnable), 32'd1);
        check("pix_addr", anOutWriteAddr, 32'd11);
        check("pix_data", 32'(anOutWriteData), 32'd5);
        aRenderPixelAddr = 32'd9;
        aRenderPixelData = 3'd7;
        step();
        check("oob_dropped", 32'(anOutWriteEnable), 32'd0);
        aRenderPixelValid = 1'b0;
        aVSync = 1'b1;
        step();
        check("render_missed", 32'(anOutMissedVSync), 32'd1);
        check("render_no_flip", 32'(anOutFrontBuffer), 32'd0);
        // Done accepted together with a vsync and a final pixel.
        aRenderDone = 1'b1;
        aRenderPixelValid = 1'b1;
        aRenderPixelAddr = 32'd0;
        aRenderPixelData = 3'd6;
        step();
        check("done_missed", 32'(anOutMissedVSync), 32'd1);
        check("done_pix_we", 32'(anOutWriteEnable), 32'd1);
        check("done_pix_addr", anOutWriteAddr, 32'd8);
        check("done_pix_data", 32'(anOutWriteData), 32'd6);
        check("done_no_flip", 32'(anOutFrontBuffer), 32'd0);
        aVSync = 1'b0;
        aRenderPixelAddr = 32'd1;
        aRenderPixelData = 3'd2;
        step();
        check("wait_pix_dropped", 32'(anOutWriteEnable), 32'd0);
        check("wait_no_missed", 32'(anOutMissedVSync), 32'd0);
        aRenderPixelValid = 1'b0;
        aVSync = 1'b1;
        step();
        check("flip1_front", 32'(anOutFrontBuffer), 32'd1);
        check("flip1_count", 32'(anOutFrameCount), 32'd1);
        check("flip1_no_we", 32'(anOutWriteEnable), 32'd0);
        check("flip1_no_missed", 32'(anOutMissedVSync), 32'd0);

        // Frame 2: clear back buffer 0, with a vsync landing during the clear.
        step();
        check("clear_missed", 32'(anOutMissedVSync), 32'd1);
        aVSync = 1'b0;
        check_clear(32'd0);
        check("clear_front_kept", 32'(anOutFrontBuffer), 32'd1);
        check("clear_missed_one", 32'(anOutMissedVSync), 32'd0);
        step();
        step();
        step();
        aVSync = 1'b1;
        step();
        check("flip2_front", 32'(anOutFrontBuffer), 32'd0);
        check("flip2_count", 32'(anOutFrameCount), 32'd2);
        check("flip2_no_missed", 32'(anOutMissedVSync), 32'd0);
        aVSync = 1'b0;
        step();

        // Frame 3: back buffer 1 again, then flip to front 1.
        check_clear(32'd8);
        step();
        step();
        step();
        aVSync = 1'b1;
        step();
        check("flip3_front", 32'(anOutFrontBuffer), 32'd1);
        check("flip3_count", 32'(anOutFrameCount), 32'd3);
        aVSync = 1'b0;
        step();
        check_clear(32'd0);

        // Reset mid-RENDER abandons the frame and restarts on buffer 1.
        step();
        aReset = 1'b1;
        step();
        check("midrst_front", 32'(anOutFrontBuffer), 32'd0);
        check("midrst_count", 32'(anOutFrameCount), 32'd0);
        check("midrst_we", 32'(anOutWriteEnable), 32'd0);
        check("midrst_start", 32'(anOutRenderStart), 32'd0);
        aReset = 1'b0;
        step();
        check_clear(32'd8);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
